// File: rtl/ccd_pixel_packer.sv
// CCD pixel packer: frames AD9826 byte pairs with an A5 5A header and a
// checksum/drop-count trailer, buffered through a 4-entry skid FIFO.
module ccd_pixel_packer #(
   parameter int COLS = 512,
   parameter int ROWS = 512
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   input  logic       byte_valid,
   input  logic [7:0] ad_data,
   input  logic       tx_fifo_wfull,
   output logic       tx_fifo_winc,
   output logic [7:0] tx_fifo_wdata,
   output logic       busy,
   output logic       overflow
);

   localparam logic [19:0] FRAME_LEN = 20'(ROWS * COLS);

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1,
      PIXELS,
      TRL_CSUM,
      TRL_DROP
   } state_t;

   state_t      state;
   logic [7:0]  skid_mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic [2:0]  count;
   logic [19:0] pix_cnt;
   logic        phase;
   logic [7:0]  csum;
   logic [7:0]  drop_cnt;

   logic        full;
   logic        empty;
   logic        pop;
   logic        push;
   logic        drop;
   logic [7:0]  push_data;

   assign full  = (count == 3'd4);
   assign empty = (count == 3'd0);
   assign pop   = !empty && !tx_fifo_wfull;
   assign drop  = byte_valid && ((state != PIXELS) || full);

   // Stay busy through the cycle that carries the final write strobe.
   assign busy = (state != IDLE) || !empty || tx_fifo_winc;

   always_comb begin
      push      = 1'b0;
      push_data = 8'h00;
      unique case (state)
         HDR0: begin
            push      = !full;
            push_data = 8'hA5;
         end
         HDR1: begin
            push      = !full;
            push_data = 8'h5A;
         end
         PIXELS: begin
            push      = byte_valid && !full;
            push_data = ad_data;
         end
         TRL_CSUM: begin
            push      = !full;
            push_data = csum;
         end
         TRL_DROP: begin
            push      = !full;
            push_data = drop_cnt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push)
         skid_mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= 2'd0;
         rd_ptr        <= 2'd0;
         count         <= 3'd0;
         tx_fifo_winc  <= 1'b0;
         tx_fifo_wdata <= 8'h00;
      end else begin
         tx_fifo_winc <= pop;
         if (pop) begin
            tx_fifo_wdata <= skid_mem[rd_ptr];
            rd_ptr        <= rd_ptr + 2'd1;
         end
         if (push)
            wr_ptr <= wr_ptr + 2'd1;
         count <= count + {2'b00, push} - {2'b00, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pix_cnt  <= 20'd0;
         phase    <= 1'b0;
         csum     <= 8'h00;
         drop_cnt <= 8'h00;
         overflow <= 1'b0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF)
               drop_cnt <= drop_cnt + 8'd1;
         end
         unique case (state)
            IDLE: begin
               // A new frame clears stats, overriding any same-cycle drop.
               if (frame_start) begin
                  pix_cnt  <= 20'd0;
                  phase    <= 1'b0;
                  csum     <= 8'h00;
                  drop_cnt <= 8'h00;
                  overflow <= 1'b0;
                  state    <= HDR0;
               end
            end
            HDR0: begin
               if (!full)
                  state <= HDR1;
            end
            HDR1: begin
               if (!full)
                  state <= PIXELS;
            end
            PIXELS: begin
               if (byte_valid) begin
                  csum  <= csum ^ ad_data;
                  phase <= !phase;
                  if (phase) begin
                     pix_cnt <= pix_cnt + 20'd1;
                     if (pix_cnt + 20'd1 == FRAME_LEN)
                        state <= TRL_CSUM;
                  end
               end
            end
            TRL_CSUM: begin
               if (!full)
                  state <= TRL_DROP;
            end
            TRL_DROP: begin
               if (!full)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ccd_pixel_packer.sv
// Directed bench for ccd_pixel_packer with a 2x2 frame (8 pixel bytes).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ccd_pixel_packer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       frame_start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] ad_data = 8'h00;
   logic       tx_fifo_wfull = 1'b0;
   logic       tx_fifo_winc;
   logic [7:0] tx_fifo_wdata;
   logic       busy;
   logic       overflow;

   int checks = 0;
   int failures = 0;

   logic [7:0] txq [$];
   logic [7:0] exp_q [$];

   always #10 clk = ~clk;

   ccd_pixel_packer #(
      .COLS(2),
      .ROWS(2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_start  (frame_start),
      .byte_valid   (byte_valid),
      .ad_data      (ad_data),
      .tx_fifo_wfull(tx_fifo_wfull),
      .tx_fifo_winc (tx_fifo_winc),
      .tx_fifo_wdata(tx_fifo_wdata),
      .busy         (busy),
      .overflow     (overflow)
   );

   always @(negedge clk) begin
      if (rst_n && tx_fifo_winc)
         txq.push_back(tx_fifo_wdata);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      byte_valid = 1'b1;
      ad_data    = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic start_frame();
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_stream(input string tag);
      chk({tag, "_len"}, txq.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < txq.size(); i++)
         chk($sformatf("%s_b%0d", tag, i), {24'd0, txq[i]},
             {24'd0, exp_q[i]});
      txq.delete();
   endtask

   initial begin
      // Reset values while rst_n is low
      #5;
      chk("rst_winc", {31'd0, tx_fifo_winc}, 32'd0);
      chk("rst_wdata", {24'd0, tx_fifo_wdata}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic frame, frame_start in first cycle after reset
      start_frame();
      chk("t1_busy", {31'd0, busy}, 32'd1);
      cyc(5);
      chk("t1_hdr_cnt", txq.size(), 32'd2);
      send(8'h01);
      chk("t1_lat1", {31'd0, tx_fifo_winc}, 32'd0);
      @(negedge clk);
      chk("t1_lat2", {31'd0, tx_fifo_winc}, 32'd1);
      chk("t1_lat2_d", {24'd0, tx_fifo_wdata}, 32'h01);
      for (int b = 2; b <= 8; b++)
         send(8'(b));
      drain("t1");
      chk("t1_ovf", {31'd0, overflow}, 32'd0);
      exp_q = {8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h08, 8'h00};
      chk_stream("t1");

      // Backpressure: 6 bytes into a 4-entry buffer
      start_frame();
      cyc(5);
      chk("t2_hdr_cnt", txq.size(), 32'd2);
      tx_fifo_wfull = 1'b1;
      for (int b = 8'h11; b <= 8'h16; b++)
         send(8'(b));
      chk("t2_ovf", {31'd0, overflow}, 32'd1);
      cyc(4);
      chk("t2_hold_cnt", txq.size(), 32'd2);
      chk("t2_hold_winc", {31'd0, tx_fifo_winc}, 32'd0);
      tx_fifo_wfull = 1'b0;
      cyc(8);
      send(8'h17);
      send(8'h18);
      drain("t2");
      chk("t2_ovf_sticky", {31'd0, overflow}, 32'd1);
      exp_q = {8'hA5, 8'h5A, 8'h11, 8'h12, 8'h13, 8'h14,
               8'h17, 8'h18, 8'h08, 8'h02};
      chk_stream("t2");

      // Second frame_start mid-frame is ignored
      start_frame();
      chk("t3_ovf_clr", {31'd0, overflow}, 32'd0);
      cyc(5);
      for (int b = 1; b <= 4; b++)
         send(8'(b));
      start_frame();
      for (int b = 5; b <= 8; b++)
         send(8'(b));
      drain("t3");
      chk("t3_ovf", {31'd0, overflow}, 32'd0);
      exp_q = {8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h08, 8'h00};
      chk_stream("t3");

      // byte_valid in IDLE, then one drop after frame_start
      send(8'h77);
      cyc(4);
      chk("t4_idle_tx", txq.size(), 32'd0);
      chk("t4_idle_ovf", {31'd0, overflow}, 32'd1);
      chk("t4_idle_busy", {31'd0, busy}, 32'd0);
      start_frame();
      send(8'h99);
      chk("t4_hdr_ovf", {31'd0, overflow}, 32'd1);
      cyc(4);
      for (int b = 1; b <= 8; b++)
         send(8'(b));
      drain("t4");
      exp_q = {8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h08, 8'h01};
      chk_stream("t4");

      // Reset during PIXELS
      start_frame();
      cyc(5);
      txq.delete();
      send(8'h01);
      send(8'h02);
      send(8'h03);
      chk("t5_pre_winc", {31'd0, tx_fifo_winc}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_winc", {31'd0, tx_fifo_winc}, 32'd0);
      chk("t5_rst_wdata", {24'd0, tx_fifo_wdata}, 32'd0);
      chk("t5_rst_busy", {31'd0, busy}, 32'd0);
      chk("t5_rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      txq.delete();
      start_frame();
      cyc(5);
      for (int b = 1; b <= 8; b++)
         send(8'(b));
      drain("t5");
      exp_q = {8'hA5, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'h07, 8'h08, 8'h08, 8'h00};
      chk_stream("t5");

      // 300 drops saturate the drop count
      tx_fifo_wfull = 1'b1;
      start_frame();
      cyc(3);
      for (int b = 8'h21; b <= 8'h28; b++)
         send(8'(b));
      chk("t6_ovf", {31'd0, overflow}, 32'd1);
      repeat (294) send(8'hEE);
      cyc(2);
      chk("t6_hold_cnt", txq.size(), 32'd0);
      tx_fifo_wfull = 1'b0;
      drain("t6");
      exp_q = {8'hA5, 8'h5A, 8'h21, 8'h22, 8'h08, 8'hFF};
      chk_stream("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
